mem_block_arbiter: RTL and testbench

- Sequences the single shared block-memory port between the instruction-side block read path and the data-side block read/write path.
- Becomes the driver of iBlkRead/dBlkRead/dBlkWrite-style traffic once the instruction and data caches are enabled.
- Arbitrates requesters with fixed priority plus a starvation guard, holds one transaction in flight, and retries on memory timeout.
- Returns a one-cycle done pulse with registered read data to the winning requester.

---
 rtl/mem_block_arbiter_if.sv | 29 ++
 rtl/mem_block_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_block_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_block_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_block_arbiter_if
//  Brief    : Shared block-memory port; master = arbiter, slave = memory.
//  Revision : 1.0
// ============================================================================
interface mem_block_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int BLK_W  = 256
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [BLK_W-1:0]  mem_wdata;
    logic [BLK_W-1:0]  mem_rdata;
    logic              mem_rd_valid;
    logic              mem_wr_valid;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_rd_valid, mem_wr_valid
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_rd_valid, mem_wr_valid
    );
endinterface
`default_nettype wire

// File: rtl/mem_block_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_block_arbiter
//  Brief    : Fixed-priority I/D block-memory arbiter with starvation guard,
//             single outstanding transaction and timeout-driven reissue.
//  Revision : 1.0
// ============================================================================
module mem_block_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64,
    parameter int ADDR_W       = 32,
    parameter int BLK_W        = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_rd,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [BLK_W-1:0]    i_rdata,
    output logic                i_done,
    input  logic                d_req_rd,
    input  logic                d_req_wr,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [BLK_W-1:0]    d_wdata,
    output logic [BLK_W-1:0]    d_rdata,
    output logic                d_done,
    mem_block_arbiter_if.master mem,
    output logic                busy,
    output logic [7:0]          retry_count
);
    localparam int c_STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int c_WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_D_STREAK);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST  = c_WAIT_W'(TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_I_RD  = 3'd1;
    localparam logic [2:0] c_ST_D_RD  = 3'd2;
    localparam logic [2:0] c_ST_D_WR  = 3'd3;
    localparam logic [2:0] c_ST_RETRY = 3'd4;
    localparam logic [2:0] c_ST_RESP  = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [2:0]            r_acc_state;
    logic [2:0]            w_grant_state;
    logic                  w_any_req;
    logic                  w_in_access;
    logic                  w_valid;
    logic [ADDR_W-1:0]     r_addr;
    logic [BLK_W-1:0]      r_wdata;
    logic [BLK_W-1:0]      r_i_rdata;
    logic [BLK_W-1:0]      r_d_rdata;
    logic [c_STREAK_W-1:0] r_streak;
    logic [c_WAIT_W-1:0]   r_wait;
    logic [7:0]            r_retry;

    // Grant decision; only consulted in IDLE when some request is high.
    always_comb begin
        w_any_req = i_req_rd | d_req_rd | d_req_wr;
        if ((r_streak == c_STREAK_MAX) && i_req_rd) begin
            w_grant_state = c_ST_I_RD;
        end else if (d_req_wr) begin
            w_grant_state = c_ST_D_WR;
        end else if (d_req_rd) begin
            w_grant_state = c_ST_D_RD;
        end else begin
            w_grant_state = c_ST_I_RD;
        end
        w_in_access = (r_state == c_ST_I_RD) || (r_state == c_ST_D_RD) ||
                      (r_state == c_ST_D_WR);
        w_valid     = (r_state == c_ST_D_WR) ? mem.mem_wr_valid
                                             : (w_in_access & mem.mem_rd_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A valid on the last wait cycle takes precedence over the timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = w_grant_state;
                end
            end
            c_ST_I_RD, c_ST_D_RD, c_ST_D_WR: begin
                if (w_valid) begin
                    w_next_state = c_ST_RESP;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_next_state = c_ST_RETRY;
                end
            end
            c_ST_RETRY: w_next_state = r_acc_state;
            c_ST_RESP:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_state <= c_ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_streak    <= '0;
            r_wait      <= '0;
            r_retry     <= '0;
        end else begin
            if ((r_state == c_ST_IDLE) && w_any_req) begin
                r_acc_state <= w_grant_state;
                r_addr      <= (w_grant_state == c_ST_I_RD) ? i_addr : d_addr;
                if (w_grant_state == c_ST_D_WR) begin
                    r_wdata <= d_wdata;
                end
                // Streak only grows while I is actually waiting behind D.
                if ((w_grant_state != c_ST_I_RD) && i_req_rd) begin
                    if (r_streak != c_STREAK_MAX) begin
                        r_streak <= r_streak + c_STREAK_W'(1);
                    end
                end else begin
                    r_streak <= '0;
                end
            end

            if (w_in_access && (w_next_state == r_state)) begin
                r_wait <= r_wait + c_WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end

            if (w_in_access && (w_next_state == c_ST_RETRY) && (r_retry != 8'hFF)) begin
                r_retry <= r_retry + 8'd1;
            end

            if (w_valid && (r_state == c_ST_I_RD)) begin
                r_i_rdata <= mem.mem_rdata;
            end
            if (w_valid && (r_state == c_ST_D_RD)) begin
                r_d_rdata <= mem.mem_rdata;
            end
        end
    end

    always_comb begin
        mem.mem_rd    = (r_state == c_ST_I_RD) || (r_state == c_ST_D_RD);
        mem.mem_wr    = (r_state == c_ST_D_WR);
        mem.mem_addr  = w_in_access ? r_addr : '0;
        mem.mem_wdata = (r_state == c_ST_D_WR) ? r_wdata : '0;
        i_done        = (r_state == c_ST_RESP) && (r_acc_state == c_ST_I_RD);
        d_done        = (r_state == c_ST_RESP) && (r_acc_state != c_ST_I_RD);
        i_rdata       = r_i_rdata;
        d_rdata       = r_d_rdata;
        busy          = (r_state != c_ST_IDLE);
        retry_count   = r_retry;
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_block_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_block_arbiter
//  Brief    : Directed bench with a transaction-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_mem_block_arbiter;
    localparam int MAX_D_STREAK = 4;
    localparam int TIMEOUT      = 8;
    localparam int ADDR_W       = 32;
    localparam int BLK_W        = 256;

    localparam int OP_NONE = 0;
    localparam int OP_I    = 1;
    localparam int OP_DRD  = 2;
    localparam int OP_DWR  = 3;
    localparam int ST_IDLE = 0;
    localparam int ST_ACC  = 1;
    localparam int ST_GAP  = 2;
    localparam int ST_RESP = 3;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [255:0] wdata;
    } dreq_t;

    logic              clk;
    logic              rst_n;
    logic              i_req_rd;
    logic [ADDR_W-1:0] i_addr;
    logic [BLK_W-1:0]  i_rdata;
    logic              i_done;
    logic              d_req_rd;
    logic              d_req_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [BLK_W-1:0]  d_wdata;
    logic [BLK_W-1:0]  d_rdata;
    logic              d_done;
    logic              busy;
    logic [7:0]        retry_count;

    mem_block_arbiter_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) mem_if ();

    mem_block_arbiter #(
        .MAX_D_STREAK(MAX_D_STREAK),
        .TIMEOUT     (TIMEOUT),
        .ADDR_W      (ADDR_W),
        .BLK_W       (BLK_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_rd   (i_req_rd),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_done     (i_done),
        .d_req_rd   (d_req_rd),
        .d_req_wr   (d_req_wr),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .mem        (mem_if),
        .busy       (busy),
        .retry_count(retry_count)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [31:0] iq[$];
    dreq_t       dq[$];
    int          lat, skip, attempt, acc_cnt;
    bit          stray, use_ab;
    int          acc_lens[$];
    logic [32:0] glog[$];
    bit          prev_busy;
    int          i_done_cnt, d_done_cnt;

    // Reference model: one transaction at a time, tracked as a coarse stage.
    int           m_stage, m_op, m_wait, m_streak, m_retries, pick_now;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata, m_irdata, m_drdata;

    function automatic int pick(input int streak, input logic ir, input logic dr, input logic dw);
        if (streak == MAX_D_STREAK && ir) return OP_I;
        if (dw) return OP_DWR;
        if (dr) return OP_DRD;
        if (ir) return OP_I;
        return OP_NONE;
    endfunction

    function automatic logic [255:0] pat(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    always_comb pick_now = pick(m_streak, i_req_rd, d_req_rd, d_req_wr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stage   <= ST_IDLE;
            m_op      <= OP_NONE;
            m_wait    <= 0;
            m_streak  <= 0;
            m_retries <= 0;
            m_addr    <= '0;
            m_wdata   <= '0;
        end else begin
            case (m_stage)
                ST_IDLE: begin
                    if (pick_now != OP_NONE) begin
                        m_stage <= ST_ACC;
                        m_op    <= pick_now;
                        m_wait  <= 0;
                        m_addr  <= (pick_now == OP_I) ? i_addr : d_addr;
                        if (pick_now == OP_DWR) m_wdata <= d_wdata;
                        if (pick_now != OP_I && i_req_rd)
                            m_streak <= (m_streak < MAX_D_STREAK) ? m_streak + 1 : MAX_D_STREAK;
                        else
                            m_streak <= 0;
                    end
                end
                ST_ACC: begin
                    if ((m_op == OP_DWR) ? mem_if.mem_wr_valid : mem_if.mem_rd_valid) begin
                        m_stage <= ST_RESP;
                        if (m_op == OP_I)   m_irdata <= mem_if.mem_rdata;
                        if (m_op == OP_DRD) m_drdata <= mem_if.mem_rdata;
                    end else if (m_wait == TIMEOUT - 1) begin
                        m_stage   <= ST_GAP;
                        m_retries <= (m_retries < 255) ? m_retries + 1 : 255;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                ST_GAP: begin
                    m_stage <= ST_ACC;
                    m_wait  <= 0;
                end
                default: m_stage <= ST_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired, got no event, expected event", name);
    endtask

    task automatic compare_step();
        logic acc;
        acc = (m_stage == ST_ACC);
        check("mem_rd", mem_if.mem_rd, acc && m_op != OP_DWR);
        check("mem_wr", mem_if.mem_wr, acc && m_op == OP_DWR);
        check("rd_wr_excl", mem_if.mem_rd & mem_if.mem_wr, 0);
        check("busy", busy, m_stage != ST_IDLE);
        check("i_done", i_done, m_stage == ST_RESP && m_op == OP_I);
        check("d_done", d_done, m_stage == ST_RESP && m_op != OP_I);
        check("retry_count", retry_count, m_retries);
        check("streak", dut.r_streak, m_streak);
        if (acc) check("mem_addr", mem_if.mem_addr, m_addr);
        if (acc && m_op == OP_DWR) check("mem_wdata", mem_if.mem_wdata, m_wdata);
        if (m_stage == ST_RESP && m_op == OP_I)   check("i_rdata", i_rdata, m_irdata);
        if (m_stage == ST_RESP && m_op == OP_DRD) check("d_rdata", d_rdata, m_drdata);
        if (busy && !prev_busy) glog.push_back({mem_if.mem_wr, mem_if.mem_addr});
        prev_busy = busy;
        if (i_done) i_done_cnt++;
        if (d_done) d_done_cnt++;
    endtask

    // Requesters and memory responder, driven 2 time units after each edge.
    task automatic drive_step();
        logic hit;
        dreq_t e;
        if (!rst_n) begin
            i_req_rd = 0; d_req_rd = 0; d_req_wr = 0;
            mem_if.mem_rd_valid = 0; mem_if.mem_wr_valid = 0;
            acc_cnt = 0;
            return;
        end
        if (i_done) i_req_rd = 0;
        else if (!i_req_rd && iq.size() > 0) begin
            i_addr   = iq.pop_front();
            i_req_rd = 1;
        end
        if (d_done) begin
            if (d_req_wr) d_req_wr = 0;
            else          d_req_rd = 0;
        end else if (!d_req_rd && !d_req_wr && dq.size() > 0) begin
            e = dq.pop_front();
            d_addr = e.addr; d_wdata = e.wdata;
            d_req_rd = e.rd; d_req_wr = e.wr;
        end
        if (mem_if.mem_rd || mem_if.mem_wr) begin
            acc_cnt++;
            if (acc_cnt == 1) attempt++;
        end else begin
            if (acc_cnt > 0) acc_lens.push_back(acc_cnt);
            acc_cnt = 0;
        end
        hit = (mem_if.mem_rd || mem_if.mem_wr) && lat != 0 && attempt > skip && acc_cnt == lat;
        mem_if.mem_rd_valid = (mem_if.mem_rd && hit) || (stray && !mem_if.mem_rd);
        mem_if.mem_wr_valid = (mem_if.mem_wr && hit) || (stray && !mem_if.mem_wr);
        mem_if.mem_rdata    = hit ? (use_ab ? {32{8'hAB}} : pat(mem_if.mem_addr)) : {8{$urandom}};
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        drive_step();
    end

    initial forever begin
        @(negedge clk);
        compare_step();
    end

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        bit idle;
        do begin
            @(negedge clk);
            n++;
            idle = iq.size() == 0 && dq.size() == 0 && !i_req_rd && !d_req_rd && !d_req_wr && !busy;
        end while (!idle && n < budget);
        if (!idle) timeout_fail(name);
    endtask

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic new_test(input int l, input int s);
        lat = l; skip = s; attempt = 0;
        acc_lens.delete();
        glog.delete();
    endtask

    initial begin
        logic [255:0] ab;
        int r, g, dd;
        ab = {32{8'hAB}};
        rst_n = 0; i_req_rd = 0; d_req_rd = 0; d_req_wr = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        mem_if.mem_rd_valid = 0; mem_if.mem_wr_valid = 0; mem_if.mem_rdata = '0;
        lat = 1; skip = 0; attempt = 0; acc_cnt = 0; stray = 0; use_ab = 0;
        prev_busy = 0; i_done_cnt = 0; d_done_cnt = 0;
        repeat (3) @(negedge clk);
        check("reset_retry_count", retry_count, 0);
        check("reset_busy", busy, 0);
        check("reset_mem_rd", mem_if.mem_rd, 0);
        #2 rst_n = 1;

        // Single I read, valid in the first access cycle.
        @(negedge clk);
        new_test(1, 0);
        use_ab = 1;
        iq.push_back(32'h400);
        g = 0;
        do begin @(negedge clk); g++; end while (!i_req_rd && g < 20);
        if (!i_req_rd) timeout_fail("t1_req");
        r = cyc;
        wait_cycle(r + 1);
        check("t1_mem_rd_c1", mem_if.mem_rd, 1);
        check("t1_mem_addr_c1", mem_if.mem_addr, 32'h400);
        wait_cycle(r + 2);
        check("t1_i_done_c2", i_done, 1);
        check("t1_i_rdata_c2", i_rdata, ab);
        wait_cycle(r + 3);
        check("t1_busy_c3", busy, 0);
        use_ab = 0;
        wait_idle("t1_idle", 50);

        // All three requesters at once.
        new_test(2, 0);
        dd = d_done_cnt;
        dq.push_back('{rd: 1'b1, wr: 1'b1, addr: 32'h800, wdata: {8{32'hDEAD_0800}}});
        iq.push_back(32'h900);
        wait_idle("t2_idle", 100);
        check("t2_glog_size", glog.size(), 3);
        check("t2_first_dwr", glog[0], {1'b1, 32'h0000_0800});
        check("t2_second_drd", glog[1], {1'b0, 32'h0000_0800});
        check("t2_third_ird", glog[2], {1'b0, 32'h0000_0900});
        check("t2_d_dones", d_done_cnt - dd, 2);

        // Starvation guard: 5th grant under a held I request goes to I.
        new_test(1, 0);
        iq.push_back(32'h1000);
        for (int k = 0; k < 6; k++)
            dq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h2000 + 32'(k) * 32'h40, wdata: '0});
        wait_idle("t3_idle", 200);
        check("t3_glog_size", glog.size(), 7);
        check("t3_grant4_d", glog[3], {1'b0, 32'h0000_20C0});
        check("t3_grant5_i", glog[4], {1'b0, 32'h0000_1000});
        check("t3_grant6_d", glog[5], {1'b0, 32'h0000_2100});
        check("t3_model_streak", m_streak, 0);

        // Timeout and reissue; answer on the 3rd cycle of the second attempt.
        new_test(3, 1);
        dd = d_done_cnt;
        dq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'hC00, wdata: '0});
        wait_idle("t4_idle", 100);
        check("t4_attempts", acc_lens.size(), 2);
        check("t4_first_len", acc_lens[0], 8);
        check("t4_second_len", acc_lens[1], 3);
        check("t4_retry_count", retry_count, 1);
        check("t4_d_done", d_done_cnt - dd, 1);

        // Valid on the final wait cycle beats the timeout.
        new_test(8, 0);
        dd = d_done_cnt;
        dq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'hD00, wdata: '0});
        wait_idle("t5_idle", 100);
        check("t5_attempts", acc_lens.size(), 1);
        check("t5_len", acc_lens[0], 8);
        check("t5_retry_count", retry_count, 1);
        check("t5_d_done", d_done_cnt - dd, 1);

        // Stray valids outside the matching access state are ignored.
        new_test(2, 0);
        stray = 1;
        dd = d_done_cnt;
        dq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'hE00, wdata: '0});
        dq.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'hE40, wdata: {8{32'hBEEF_0E40}}});
        wait_idle("t6_idle", 100);
        stray = 0;
        check("t6_attempts", acc_lens.size(), 2);
        check("t6_d_dones", d_done_cnt - dd, 2);
        check("t6_retry_count", retry_count, 1);

        // Reset in the middle of a write.
        new_test(0, 0);
        dq.push_back('{rd: 1'b0, wr: 1'b1, addr: 32'hF00, wdata: {8{32'h1234_0F00}}});
        g = 0;
        do begin @(negedge clk); g++; end while (!mem_if.mem_wr && g < 20);
        if (!mem_if.mem_wr) timeout_fail("t7_mem_wr");
        repeat (2) @(negedge clk);
        dd = d_done_cnt;
        #2 rst_n = 0;
        dq.delete();
        #1;
        check("t7_mem_wr_async", mem_if.mem_wr, 0);
        check("t7_busy_async", busy, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        repeat (5) @(negedge clk);
        check("t7_busy_after", busy, 0);
        check("t7_no_d_done", d_done_cnt - dd, 0);
        check("t7_retry_cleared", retry_count, 0);

        // retry_count saturates at 255.
        new_test(0, 0);
        dq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h3000, wdata: '0});
        repeat (2400) @(negedge clk);
        check("t8_retry_sat", retry_count, 255);
        check("t8_busy", busy, 1);
        #2 rst_n = 0;
        dq.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        repeat (3) @(negedge clk);
        check("t8_retry_reset", retry_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
